// File: rtl/mdu_pkg.sv
// Shared constants, op encodings and FSM states for the iterative MIPS multiply/divide unit.
package mdu_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

  localparam logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  // Magnitude of a two's-complement value when it is treated as signed.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Pipeline-facing bus of the multiply/divide unit: op launch, HI/LO moves and status.
interface mul_div_unit_if;
  import mdu_pkg::*;

  logic            start;
  mdu_op_e         op;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] rt_data;
  logic            mt_hi;
  logic            mt_lo;
  logic            mf_sel;
  logic [XLEN-1:0] mf_data;
  logic            busy;
  logic            done;
  logic            div_zero;

  modport master (
    output start, op, rs_data, rt_data, mt_hi, mt_lo, mf_sel,
    input  mf_data, busy, done, div_zero
  );

  modport slave (
    input  start, op, rs_data, rt_data, mt_hi, mt_lo, mf_sel,
    output mf_data, busy, done, div_zero
  );

endinterface

// File: rtl/mdu_iter_core.sv
// One unsigned iteration step: shift-add for multiply, restoring subtract for divide.
module mdu_iter_core
  import mdu_pkg::*;
(
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_hi,
  input  logic [XLEN-1:0] acc_lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] next_hi,
  output logic [XLEN-1:0] next_lo
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  // Multiply keeps the multiplier in acc_lo and shifts product bits in from the top;
  // divide keeps the partial remainder in acc_hi and shifts quotient bits into acc_lo.
  always_comb begin
    sum     = {1'b0, acc_hi} + {1'b0, operand};
    shifted = {acc_hi, acc_lo[XLEN-1]};
    diff    = shifted[XLEN-1:0] - operand;
    next_hi = acc_hi;
    next_lo = acc_lo;
    if (is_div) begin
      if (shifted >= {1'b0, operand}) begin
        next_hi = diff;
        next_lo = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        next_hi = shifted[XLEN-1:0];
        next_lo = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else if (acc_lo[0]) begin
      {next_hi, next_lo} = {sum, acc_lo[XLEN-1:1]};
    end else begin
      {next_hi, next_lo} = {1'b0, acc_hi, acc_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO/MFHI/MFLO access.
// Define MDU_FAST_MULT_EN to compute multiplies in a single cycle with an inferred '*'.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  mul_div_unit_if.slave      bus
);

  mdu_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] acc_hi_q, acc_hi_d;
  logic [XLEN-1:0] acc_lo_q, acc_lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic            is_div_q, is_div_d;
  logic            neg_q, neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic            div0_q, div0_d;
  logic            done_q, done_d;
  logic            div_zero_q, div_zero_d;

  logic [XLEN-1:0]   core_hi, core_lo;
  logic              signed_op, a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [2*XLEN-1:0] product;

  mdu_iter_core u_core (
    .is_div  (is_div_q),
    .acc_hi  (acc_hi_q),
    .acc_lo  (acc_lo_q),
    .operand (opb_q),
    .next_hi (core_hi),
    .next_lo (core_lo)
  );

  // Both multiply and divide start from {0, |A|}; sign handling is deferred to FIX.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opb_d      = opb_q;
    dividend_d = dividend_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div0_d     = div0_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    signed_op  = ~bus.op[0];
    a_neg      = signed_op & bus.rs_data[XLEN-1];
    b_neg      = signed_op & bus.rt_data[XLEN-1];
    abs_a      = abs_val(bus.rs_data, signed_op);
    abs_b      = abs_val(bus.rt_data, signed_op);
    product    = {acc_hi_q, acc_lo_q};

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          is_div_d   = bus.op[1];
          neg_d      = a_neg ^ b_neg;
          rem_neg_d  = a_neg;
          opb_d      = abs_b;
          dividend_d = bus.rs_data;
          acc_hi_d   = '0;
          acc_lo_d   = abs_a;
          cnt_d      = '0;
          div0_d     = bus.op[1] && (bus.rt_data == '0);
          div_zero_d = 1'b0;
          state_d    = ST_RUN;
          if (bus.op[1] && (bus.rt_data == '0)) begin
            state_d = ST_FIX;
          end
`ifdef MDU_FAST_MULT_EN
          if (!bus.op[1]) begin
            {acc_hi_d, acc_lo_d} = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
            state_d = ST_FIX;
          end
`endif
        end else begin
          if (bus.mt_hi) hi_d = bus.rs_data;
          if (bus.mt_lo) lo_d = bus.rs_data;
        end
      end

      ST_RUN: begin
        acc_hi_d = core_hi;
        acc_lo_d = core_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERS-1)) state_d = ST_FIX;
      end

      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (div0_q) begin
          hi_d       = dividend_q;
          lo_d       = DIV0_LO;
          div_zero_d = 1'b1;
        end else if (is_div_q) begin
          lo_d = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
          hi_d = rem_neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
        end else begin
          if (neg_q) product = ~product + 1'b1;
          {hi_d, lo_d} = product;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opb_q      <= '0;
      dividend_q <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div0_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opb_q      <= opb_d;
      dividend_q <= dividend_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div0_q     <= div0_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.mf_data  = bus.mf_sel ? hi_q : lo_q;

endmodule
